piso_serializer: RTL and testbench

Parallel-in serial-out serializer that consumes the 4-bit word produced by the parallel register stage and shifts it onto a single-bit serial line. It uses a valid/ready load handshake and frame-boundary flags. Back-to-back words are accepted without gaps. It sits directly downstream of the parallel holding register and feeds the serial link / serial-in receivers.

---
 rtl/piso_serializer.sv | 96 +++++++++
 tb/tb_piso_serializer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with valid/ready load and frame flags.
// All serial outputs are registered from the next-state values so they change only on clk.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] parallel_in,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             frame_done,
    output logic             busy
);
    // Handshake: a word is accepted on a rising edge where load_valid && load_ready.
    // load_ready is combinational from registered state; parallel_in is sampled only on accept.

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    idx_d;
    logic             accept;
    logic             out_d, valid_d, start_d, done_d;

    assign load_ready = (state_q == IDLE) || (cnt_q == LAST);
    assign accept     = load_valid && load_ready;
    assign busy       = (state_q == SHIFT);

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sreg_d  = parallel_in;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == LAST) begin
                    if (accept) begin
                        sreg_d = parallel_in;
                        cnt_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output values for the cycle after this edge, derived from the next state.
    always_comb begin
        idx_d   = MSB_FIRST ? (LAST - cnt_d) : cnt_d;
        valid_d = (state_d == SHIFT);
        out_d   = valid_d && sreg_d[idx_d];
        start_d = valid_d && (cnt_d == '0);
        done_d  = valid_d && (cnt_d == LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sreg_q       <= '0;
            cnt_q        <= '0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            frame_start  <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sreg_q       <= sreg_d;
            cnt_q        <= cnt_d;
            serial_out   <= out_d;
            serial_valid <= valid_d;
            frame_start  <= start_d;
            frame_done   <= done_d;
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share stimulus;
// each has a per-cycle expected queue of {bit, frame_start, frame_done}.
module tb_piso_serializer;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_valid;
    logic [W-1:0] parallel_in;

    logic m_ready, m_out, m_valid, m_start, m_done, m_busy;
    logic l_ready, l_out, l_valid, l_start, l_done, l_busy;

    logic [2:0] exp_m[$];
    logic [2:0] exp_l[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(m_ready),
        .parallel_in(parallel_in), .serial_out(m_out), .serial_valid(m_valid),
        .frame_start(m_start), .frame_done(m_done), .busy(m_busy)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(l_ready),
        .parallel_in(parallel_in), .serial_out(l_out), .serial_valid(l_valid),
        .frame_start(l_start), .frame_done(l_done), .busy(l_busy)
    );

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    task automatic check_side(input string tag, input bit have, input logic [2:0] e,
                              input bit rdy_exp, input logic rdy, input logic vld,
                              input logic o, input logic st, input logic dn, input logic bsy);
        chk({tag, ".valid"}, {2'b00, vld}, {2'b00, have});
        chk({tag, ".busy"},  {2'b00, bsy}, {2'b00, have});
        chk({tag, ".ready"}, {2'b00, rdy}, {2'b00, rdy_exp});
        chk({tag, ".bit_start_done"}, {o, st, dn}, have ? e : 3'b000);
    endtask

    task automatic push_word(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) begin
            exp_m.push_back({w[W-1-i], i == 0, i == W-1});
            exp_l.push_back({w[i],     i == 0, i == W-1});
        end
    endtask

    task automatic check_now(input string tag);
        bit         have_m, have_l;
        logic [2:0] em, el;
        have_m = exp_m.size() > 0;
        have_l = exp_l.size() > 0;
        em = have_m ? exp_m.pop_front() : 3'b000;
        el = have_l ? exp_l.pop_front() : 3'b000;
        check_side({tag, ".msb"}, have_m, em, exp_m.size() == 0,
                   m_ready, m_valid, m_out, m_start, m_done, m_busy);
        check_side({tag, ".lsb"}, have_l, el, exp_l.size() == 0,
                   l_ready, l_valid, l_out, l_start, l_done, l_busy);
    endtask

    // Advance one cycle; the model decides accept from its own queue, not from the DUT.
    task automatic tick(input string tag);
        bit           acc;
        logic [W-1:0] w;
        acc = load_valid && (exp_m.size() == 0) && !rst;
        w   = parallel_in;
        @(posedge clk);
        if (acc) push_word(w);
        #1;
        check_now(tag);
    endtask

    initial begin
        rst = 1'b1;
        load_valid = 1'b0;
        parallel_in = '0;
        #11;
        check_now("reset");
        #1 rst = 1'b0;
        tick("idle0");
        #2 rst = 1'b1;
        #1 check_now("idle_rst");
        #1 rst = 1'b0;
        tick("idle1");
        tick("idle2");

        // single word 1011
        load_valid = 1'b1; parallel_in = 4'b1011;
        tick("single");
        load_valid = 1'b0; parallel_in = W'($urandom_range(0, 15));
        for (int i = 0; i < 4; i++) tick("single");

        // back-to-back 1011 then 0110
        load_valid = 1'b1; parallel_in = 4'b1011;
        tick("b2b");
        parallel_in = 4'b0110;
        for (int i = 0; i < 4; i++) tick("b2b");
        load_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick("b2b");

        // load pulse during a frame is ignored
        load_valid = 1'b1; parallel_in = 4'b0001;
        tick("ignored");
        load_valid = 1'b0;
        tick("ignored");
        load_valid = 1'b1; parallel_in = 4'b1111;
        tick("ignored");
        load_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick("ignored");

        // reset in cycle 2 of a frame discards it
        load_valid = 1'b1; parallel_in = 4'b1011;
        tick("midrst");
        load_valid = 1'b0;
        tick("midrst");
        rst = 1'b1;
        exp_m.delete();
        exp_l.delete();
        #1 check_now("midrst_async");
        #2 rst = 1'b0;
        tick("midrst_after");
        load_valid = 1'b1; parallel_in = 4'b0101;
        tick("post_rst");
        load_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick("post_rst");

        // random traffic; upstream holds its word until the model accepts it
        for (int n = 0; n < 40; n++) begin
            if (!load_valid || exp_m.size() == 0) begin
                load_valid  = ($urandom_range(0, 3) != 0);
                parallel_in = W'($urandom_range(0, 15));
            end
            tick("random");
        end
        load_valid = 1'b0;
        for (int i = 0; i < W + 1; i++) tick("drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
